// File: rtl/fan_pkg.sv
// Shared constants, FSM state encoding and duty clamp helper for the fan PWM blocks.
// Latency: none (declarations only).
// Backpressure: not applicable.
//
// Contents:
//   DUTY_MAX          - largest legal duty in percent (100)
//   STEPS_PER_PERIOD  - duty steps in one PWM period (100)
//   STEP_LAST         - index of the final step in a period
//   fan_state_e       - ramp controller states
//   clamp_duty()      - saturates a 7-bit duty request to DUTY_MAX
package fan_pkg;

    localparam logic [6:0] DUTY_MAX         = 7'd100;
    localparam int         STEPS_PER_PERIOD = 100;
    localparam logic [6:0] STEP_LAST        = 7'(STEPS_PER_PERIOD - 1);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,   // duty_cur == 0 and target == 0
        ST_RAMP_UP   = 2'd1,   // duty_cur below target
        ST_RAMP_DOWN = 2'd2,   // duty_cur above target
        ST_HOLD      = 2'd3    // duty_cur == target, non-zero
    } fan_state_e;

    // A 7-bit request can encode 101..127; those saturate to full drive.
    function automatic logic [6:0] clamp_duty(input logic [6:0] d);
        return (d > DUTY_MAX) ? DUTY_MAX : d;
    endfunction

endpackage

// File: rtl/fan_pwm_prescaler.sv
// Free-running clk divider producing one tick per duty step of the PWM generator.
// Latency: tick is combinational from the registered count; pre_zero likewise.
// Backpressure: none; the counter never stalls.
//
// Ports:
//   clk      - system clock
//   reset_p  - synchronous active-high reset, clears the count to 0
//   tick     - high on the last clk of each CLK_DIV-cycle slot
//   pre_zero - high on the first clk of each CLK_DIV-cycle slot
module fan_pwm_prescaler #(
    parameter int CLK_DIV = 100
) (
    input  logic clk,
    input  logic reset_p,
    output logic tick,
    output logic pre_zero
);

    // Keep at least one bit so CLK_DIV == 1 still elaborates; tick and
    // pre_zero are then both permanently high.
    localparam int            PW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(CLK_DIV - 1);

    logic [PW-1:0] pre_q;
    logic [PW-1:0] pre_d;

    assign tick     = (pre_q == PRE_LAST);
    assign pre_zero = (pre_q == '0);

    always_comb begin
        pre_d = pre_q;
        if (tick) begin
            pre_d = '0;
        end else begin
            pre_d = pre_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset_p) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_d;
        end
    end

endmodule

// File: rtl/fan_pwm_gen.sv
// Fan/LED PWM generator with rate-limited duty ramping between period boundaries.
// Latency: a duty sampled at the end of a period drives pwm from the first clk of the next.
// Backpressure: none; duty is only looked at on the end-of-period edge.
//
// Ports:
//   clk          - system clock (single domain)
//   reset_p      - synchronous active-high reset
//   duty         - requested duty in percent, 101..127 treated as 100
//   pwm          - registered drive output
//   duty_cur     - duty applied during the current period
//   period_start - one-clk pulse on the first clk of every period
//   ramping      - high while the controller is moving duty_cur toward target
module fan_pwm_gen
    import fan_pkg::*;
#(
    parameter int CLK_DIV   = 100,
    parameter int RAMP_STEP = 10
) (
    input  logic       clk,
    input  logic       reset_p,
    input  logic [6:0] duty,
    output logic       pwm,
    output logic [6:0] duty_cur,
    output logic       period_start,
    output logic       ramping
);

    // A step larger than the full range behaves the same as a full-range step.
    localparam int         RS_LIM = (RAMP_STEP > int'(DUTY_MAX)) ? int'(DUTY_MAX) : RAMP_STEP;
    localparam logic [6:0] RS_W   = 7'(RS_LIM);

    logic       tick;
    logic       pre_zero;
    logic       end_of_period;

    logic [6:0] step_q;
    logic [6:0] step_d;
    logic [6:0] duty_cur_q;
    logic [6:0] duty_cur_d;
    logic [6:0] target_q;
    logic [6:0] target_d;
    logic       pwm_q;
    logic       pwm_d;
    logic [6:0] gap;

    fan_state_e state_q;
    fan_state_e state_d;

    fan_pwm_prescaler #(
        .CLK_DIV (CLK_DIV)
    ) u_prescaler (
        .clk      (clk),
        .reset_p  (reset_p),
        .tick     (tick),
        .pre_zero (pre_zero)
    );

    assign end_of_period = tick && (step_q == STEP_LAST);

    // ------------------------------------------------------------------
    // Step counter: one step per prescaler tick, 0..STEP_LAST.
    // ------------------------------------------------------------------
    always_comb begin
        step_d = step_q;
        if (tick) begin
            if (step_q == STEP_LAST) begin
                step_d = '0;
            end else begin
                step_d = step_q + 7'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Target sample and rate-limited duty update, end-of-period only.
    // The gap is clipped to RS_W so duty_cur lands exactly on target when
    // it is close, and can never cross it (no overshoot on reversal).
    // ------------------------------------------------------------------
    always_comb begin
        target_d   = target_q;
        duty_cur_d = duty_cur_q;
        gap        = '0;
        if (end_of_period) begin
            target_d = clamp_duty(duty);
            if (target_d > duty_cur_q) begin
                gap        = target_d - duty_cur_q;
                duty_cur_d = duty_cur_q + ((gap > RS_W) ? RS_W : gap);
            end else if (target_d < duty_cur_q) begin
                gap        = duty_cur_q - target_d;
                duty_cur_d = duty_cur_q - ((gap > RS_W) ? RS_W : gap);
            end
        end
    end

    // ------------------------------------------------------------------
    // Ramp FSM: transitions judged on the post-update duty_cur/target.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        if (end_of_period) begin
            case (state_q)
                ST_IDLE: begin
                    if (target_d != 7'd0) begin
                        // A first step within RAMP_STEP lands directly on target.
                        state_d = (duty_cur_d == target_d) ? ST_HOLD : ST_RAMP_UP;
                    end
                end
                ST_RAMP_UP, ST_RAMP_DOWN, ST_HOLD: begin
                    if (duty_cur_d == target_d) begin
                        state_d = (target_d == 7'd0) ? ST_IDLE : ST_HOLD;
                    end else if (target_d > duty_cur_d) begin
                        state_d = ST_RAMP_UP;
                    end else begin
                        state_d = ST_RAMP_DOWN;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Compare against the next-cycle step and duty so the registered pwm
    // lines up with step_q/duty_cur_q; the new duty therefore appears on
    // the very first clk of the following period, and 0 / 100 give
    // constant levels.
    always_comb begin
        pwm_d = (step_d < duty_cur_d);
    end

    always_ff @(posedge clk) begin
        if (reset_p) begin
            step_q     <= '0;
            duty_cur_q <= '0;
            target_q   <= '0;
            pwm_q      <= 1'b0;
            state_q    <= ST_IDLE;
        end else begin
            step_q     <= step_d;
            duty_cur_q <= duty_cur_d;
            target_q   <= target_d;
            pwm_q      <= pwm_d;
            state_q    <= state_d;
        end
    end

    assign pwm          = pwm_q;
    assign duty_cur     = duty_cur_q;
    assign period_start = pre_zero && (step_q == 7'd0);
    assign ramping      = (state_q == ST_RAMP_UP) || (state_q == ST_RAMP_DOWN);

endmodule

// File: tb/tb_fan_pwm_gen.sv
// Bench for fan_pwm_gen: two instances (RAMP_STEP 10 and 25, CLK_DIV 2) share
// all inputs; a period-level model predicts every output on every cycle, and
// directed scenarios pin the model with hand-computed duty/high-count values.
module tb_fan_pwm_gen;

    localparam int PERIOD = 200;   // 100 steps x CLK_DIV 2

    logic       clk = 1'b0;
    logic       reset_p;
    logic [6:0] duty;

    logic       pwm_a, period_start_a, ramping_a;
    logic [6:0] duty_cur_a;
    logic       pwm_b, period_start_b, ramping_b;
    logic [6:0] duty_cur_b;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    fan_pwm_gen #(.CLK_DIV(2), .RAMP_STEP(10)) u_dut_a (
        .clk          (clk),
        .reset_p      (reset_p),
        .duty         (duty),
        .pwm          (pwm_a),
        .duty_cur     (duty_cur_a),
        .period_start (period_start_a),
        .ramping      (ramping_a)
    );

    fan_pwm_gen #(.CLK_DIV(2), .RAMP_STEP(25)) u_dut_b (
        .clk          (clk),
        .reset_p      (reset_p),
        .duty         (duty),
        .pwm          (pwm_b),
        .duty_cur     (duty_cur_b),
        .period_start (period_start_b),
        .ramping      (ramping_b)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Model: cycle index within the current period since the last reset
    // edge, plus per-instance applied duty and the shared clamped target.
    // ------------------------------------------------------------------
    int cyc;
    int cur [2];
    int tgt;
    int rs  [2] = '{10, 25};
    bit model_valid = 1'b0;

    always @(posedge clk) begin
        if (reset_p) begin
            cyc         = 0;
            cur[0]      = 0;
            cur[1]      = 0;
            tgt         = 0;
            model_valid = 1'b1;
        end else if (model_valid) begin
            if (cyc % PERIOD == PERIOD - 1) begin
                tgt = (int'(duty) > 100) ? 100 : int'(duty);
                for (int i = 0; i < 2; i++) begin
                    if (tgt > cur[i])
                        cur[i] = cur[i] + (((tgt - cur[i]) < rs[i]) ? (tgt - cur[i]) : rs[i]);
                    else if (tgt < cur[i])
                        cur[i] = cur[i] - (((cur[i] - tgt) < rs[i]) ? (cur[i] - tgt) : rs[i]);
                end
            end
            cyc = cyc + 1;
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin : cmp
        int p;
        if (model_valid) begin
            p = cyc % PERIOD;
            chk("a_period_start", period_start_a, p == 0);
            chk("a_pwm",          pwm_a,          (p / 2) < cur[0]);
            chk("a_duty_cur",     duty_cur_a,     cur[0]);
            chk("a_ramping",      ramping_a,      cur[0] != tgt);
            chk("b_period_start", period_start_b, p == 0);
            chk("b_pwm",          pwm_b,          (p / 2) < cur[1]);
            chk("b_duty_cur",     duty_cur_b,     cur[1]);
            chk("b_ramping",      ramping_b,      cur[1] != tgt);
        end
    end

    // Measures one period starting at the current negedge (a period start).
    // Optionally changes duty chg_at clks into the period.
    task automatic measure(input int chg_at, input logic [6:0] chg_val,
                           output int hi, output int dc, output int rmp, output int dcb);
        hi  = 0;
        dc  = int'(duty_cur_a);
        dcb = int'(duty_cur_b);
        rmp = int'(ramping_a);
        chk("measure_aligned", period_start_a, 1);
        for (int k = 0; k < PERIOD; k++) begin
            if (k == chg_at) duty = chg_val;
            if (pwm_a === 1'b1) hi++;
            @(negedge clk);
        end
    endtask

    task automatic run_periods(input int n);
        int h, d, r, db;
        for (int k = 0; k < n; k++) measure(-1, 7'd0, h, d, r, db);
    endtask

    initial begin : stim
        int h, d, r, db, ps_cnt, hi_cnt, rmp_cnt;
        int e_dc [5];
        int e_hi [5];
        int e_rm [5];
        int e_b  [5];

        reset_p = 1'b1;
        duty    = 7'd0;
        repeat (3) @(negedge clk);
        chk("rst_pwm",          pwm_a,          0);
        chk("rst_duty_cur",     duty_cur_a,     0);
        chk("rst_ramping",      ramping_a,      0);
        chk("rst_period_start", period_start_a, 1);
        reset_p = 1'b0;

        // Idle at duty 0 for 5 periods.
        ps_cnt = 0; hi_cnt = 0; rmp_cnt = 0;
        for (int k = 0; k < 5 * PERIOD; k++) begin
            if (period_start_a === 1'b1) ps_cnt++;
            if (pwm_a === 1'b1) hi_cnt++;
            if (ramping_a === 1'b1) rmp_cnt++;
            @(negedge clk);
        end
        chk("idle_ps_count",  ps_cnt,  5);
        chk("idle_pwm_high",  hi_cnt,  0);
        chk("idle_ramping",   rmp_cnt, 0);

        // Ramp from IDLE to 30.
        duty = 7'd30;
        e_dc = '{0, 10, 20, 30, 30};
        e_hi = '{0, 20, 40, 60, 60};
        e_rm = '{0, 1, 1, 0, 0};
        for (int k = 0; k < 4; k++) begin
            measure(-1, 7'd0, h, d, r, db);
            chk($sformatf("up30_dc_p%0d", k + 1), d, e_dc[k]);
            chk($sformatf("up30_hi_p%0d", k + 1), h, e_hi[k]);
            chk($sformatf("up30_rm_p%0d", k + 1), r, e_rm[k]);
        end

        // In HOLD at 30, request 60 mid-period: current period unaffected.
        e_dc = '{30, 40, 50, 60, 60};
        e_hi = '{60, 80, 100, 120, 120};
        e_rm = '{0, 1, 1, 0, 0};
        for (int k = 0; k < 4; k++) begin
            measure((k == 0) ? 50 : -1, 7'd60, h, d, r, db);
            chk($sformatf("mid60_dc_p%0d", k), d, e_dc[k]);
            chk($sformatf("mid60_hi_p%0d", k), h, e_hi[k]);
            chk($sformatf("mid60_rm_p%0d", k), r, e_rm[k]);
        end

        // Back to HOLD at 30, then ramp down to 0.
        duty = 7'd30;
        run_periods(3);
        duty = 7'd0;
        e_dc = '{30, 20, 10, 0, 0};
        e_hi = '{60, 40, 20, 0, 0};
        e_rm = '{0, 1, 1, 0, 0};
        for (int k = 0; k < 5; k++) begin
            measure(-1, 7'd0, h, d, r, db);
            chk($sformatf("dn0_dc_p%0d", k), d, e_dc[k]);
            chk($sformatf("dn0_hi_p%0d", k), h, e_hi[k]);
            chk($sformatf("dn0_rm_p%0d", k), r, e_rm[k]);
        end

        // RAMP_STEP 25 instance: 90 down to 0.
        duty = 7'd90;
        run_periods(10);
        duty = 7'd0;
        e_b = '{90, 65, 40, 15, 0};
        for (int k = 0; k < 5; k++) begin
            measure(-1, 7'd0, h, d, r, db);
            chk($sformatf("b_dn_dc_p%0d", k), db, e_b[k]);
        end

        // Clamp 127 -> 100 from IDLE.
        run_periods(5);
        duty = 7'd127;
        for (int k = 0; k < 12; k++) begin
            measure(-1, 7'd0, h, d, r, db);
            chk($sformatf("clamp_dc_p%0d", k), d, (k * 10 > 100) ? 100 : k * 10);
            if (k >= 10) chk($sformatf("clamp_hi_p%0d", k), h, PERIOD);
        end
        chk("clamp_b_dc", duty_cur_b, 100);

        // Reset mid-ramp at duty_cur 50.
        reset_p = 1'b1;
        repeat (2) @(negedge clk);
        reset_p = 1'b0;
        duty = 7'd90;
        run_periods(5);
        repeat (77) @(negedge clk);
        chk("pre_rst_dc",  duty_cur_a, 50);
        chk("pre_rst_pwm", pwm_a,      1);
        reset_p = 1'b1;
        @(negedge clk);
        chk("mid_rst_pwm",     pwm_a,          0);
        chk("mid_rst_dc",      duty_cur_a,     0);
        chk("mid_rst_ramping", ramping_a,      0);
        chk("mid_rst_ps",      period_start_a, 1);
        reset_p = 1'b0;
        e_dc = '{0, 10, 20, 30, 40};
        e_hi = '{0, 20, 40, 60, 80};
        for (int k = 0; k < 3; k++) begin
            measure(-1, 7'd0, h, d, r, db);
            chk($sformatf("restart_dc_p%0d", k), d, e_dc[k]);
            chk($sformatf("restart_hi_p%0d", k), h, e_hi[k]);
        end

        // Randomized duty changes and occasional resets, checked by the model.
        for (int k = 0; k < 40; k++) begin
            duty = 7'($urandom_range(0, 127));
            repeat ($urandom_range(1, 600)) @(negedge clk);
            if ($urandom_range(0, 9) == 0) begin
                reset_p = 1'b1;
                repeat ($urandom_range(1, 3)) @(negedge clk);
                reset_p = 1'b0;
            end
        end
        repeat (5) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
